// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store stage.
//   state_t          : access FSM encoding (IDLE, REQ, DONE)
//   ERR_DATA_DEFAULT : load data returned when the bus never acknowledges
//   ALIGN_MASK       : byte-offset bits that must be zero for a word access
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
    localparam logic [1:0]  ALIGN_MASK       = 2'b11;

    // True when the byte offset selects a whole, aligned word.
    function automatic logic is_aligned(input logic [1:0] byte_off);
        return (byte_off & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_access_if.sv
// Word-addressed req/ack bus between the load/store stage and RAM/peripherals.
//   bus_req   : request, held until acknowledged        (master -> slave)
//   bus_we    : 1 = write, 0 = read                      (master -> slave)
//   bus_addr  : word address                             (master -> slave)
//   bus_wdata : write data                               (master -> slave)
//   bus_rdata : read data, valid with bus_ack            (slave -> master)
//   bus_ack   : single-cycle acknowledge                 (slave -> master)
interface data_mem_access_if #(
    parameter int unsigned DATA_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [DATA_W-3:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/data_mem_access_timeout_counter.sv
// Watchdog counter for the request phase.
//   clk, reset : clock, synchronous active-high reset
//   i_clear    : force count to zero (used whenever no request is outstanding)
//   i_enable   : count one cycle
//   o_tc_c     : count has reached TIMEOUT-1 (combinational decode of the count)
module timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc_c
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_count;

    // Saturates at the terminal count so it can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_tc_c) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tc_c = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/data_mem_access.sv
// Load/store stage: turns a single-cycle LDR/STR into a req/ack bus transaction
// and stalls the datapath until the access completes.
//   clk, reset          : clock, synchronous active-high reset
//   MemRead, MemWrite   : decoded load/store of the current instruction
//   ALUResult           : byte address from the datapath
//   WriteData           : store data from the datapath
//   ReadData            : load result to the datapath result mux
//   Stall               : hold PC / gate RegWrite while high (combinational)
//   MemErr              : one-cycle pulse on misalignment or bus timeout
//   bus                 : master side of the word-addressed req/ack bus
module data_mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              MemErr,
    data_mem_access_if.master bus
);

    state_t            r_state;
    logic              r_we;
    logic [DATA_W-3:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_acc;
    logic              w_aligned;
    logic              w_in_req;
    logic              w_tc;

    assign w_acc     = MemRead | MemWrite;
    assign w_aligned = is_aligned(ALUResult[1:0]);
    assign w_in_req  = (r_state == REQ);

    // Watchdog only runs while a request is outstanding.
    timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (!w_in_req),
        .i_enable (w_in_req),
        .o_tc_c   (w_tc)
    );

    // Access FSM with registered bus fields, load data and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        if (w_aligned) begin
                            // MemWrite wins when both are set: access is a store.
                            r_we    <= MemWrite;
                            r_addr  <= ALUResult[DATA_W-1:2];
                            r_wdata <= WriteData;
                            r_state <= REQ;
                        end else begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // An ack on the terminal-count cycle still counts as success.
                    if (bus.bus_ack) begin
                        if (!r_we) r_rdata <= bus.bus_rdata;
                        r_state <= DONE;
                    end else if (w_tc) begin
                        if (!r_we) r_rdata <= ERR_DATA;
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // The retiring instruction is still presented; never restart here.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Stall rises in the same cycle the access is presented so the PC holds.
    assign Stall         = w_in_req | ((r_state == IDLE) & w_acc & w_aligned);
    assign MemErr        = r_err;
    assign ReadData      = r_rdata;
    assign bus.bus_req   = w_in_req;
    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_wdata = r_wdata;

endmodule

// File: tb/tb_data_mem_access.sv
// Bench for data_mem_access: a transaction-level model of the stage plus an
// echoing bus slave; expected per-cycle outputs come from each instruction's
// planned ack delay.
module tb_data_mem_access;
    import mem_access_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;
    localparam logic [31:0] ERRV = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemRead, MemWrite;
    logic [DW-1:0] ALUResult, WriteData, ReadData;
    logic          Stall, MemErr;

    data_mem_access_if #(.DATA_W(DW)) mem_bus ();

    data_mem_access #(
        .DATA_W   (DW),
        .TIMEOUT  (TO),
        .ERR_DATA (ERRV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .MemErr    (MemErr),
        .bus       (mem_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs for the current cycle.
    logic          chk_en = 1'b0;
    logic          exp_stall, exp_req, exp_err, exp_we;
    logic [DW-3:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rd;
    // Effects that become visible one cycle later.
    logic          pend_err = 1'b0;
    logic [DW-1:0] pend_rd  = '0;

    // Observed activity, cleared per directed scenario.
    int            stall_cnt, req_cnt, err_cnt, req_rise;
    logic          prev_req = 1'b0;
    logic [DW-3:0] last_addr;

    logic [DW-1:0] mem [logic [DW-3:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: one pass per cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall",    32'(Stall),           32'(exp_stall));
            check("bus_req",  32'(mem_bus.bus_req), 32'(exp_req));
            check("memerr",   32'(MemErr),          32'(exp_err));
            check("readdata", ReadData,             exp_rd);
            if (exp_req) begin
                check("bus_we",    32'(mem_bus.bus_we),   32'(exp_we));
                check("bus_addr",  32'(mem_bus.bus_addr), 32'(exp_addr));
                check("bus_wdata", mem_bus.bus_wdata,     exp_wdata);
            end
            if (Stall) stall_cnt++;
            if (mem_bus.bus_req) begin
                req_cnt++;
                last_addr = mem_bus.bus_addr;
                if (!prev_req) req_rise++;
            end
            if (MemErr) err_cnt++;
            prev_req = mem_bus.bus_req;
        end
    end

    task automatic clear_counts();
        stall_cnt = 0; req_cnt = 0; err_cnt = 0; req_rise = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        exp_err  = pend_err;
        pend_err = 1'b0;
        exp_rd   = pend_rd;
        mem_bus.bus_ack   = 1'b0;
        mem_bus.bus_rdata = $urandom;
    endtask

    // Stray acks outside a request must be ignored.
    task automatic bus_noise();
        mem_bus.bus_ack = ($urandom_range(0, 3) == 0);
    endtask

    // Present one instruction until it retires; the slave acks k cycles after
    // bus_req rises (k >= TO means never). Returns in the next instruction's cycle.
    task automatic run_instr(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input int k);
        int n;
        MemRead = rd; MemWrite = wr; ALUResult = addr; WriteData = wd;
        exp_req = 1'b0;
        if (!(rd | wr) || addr[1:0] != 2'b00) begin
            exp_stall = 1'b0;
            if (rd | wr) begin
                pend_err = 1'b1;
                pend_rd  = '0;
            end
            bus_noise();
            next_cycle();
            return;
        end
        exp_stall = 1'b1;
        bus_noise();
        n = (k < int'(TO)) ? k + 1 : int'(TO);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            exp_req = 1'b1; exp_stall = 1'b1;
            exp_we = wr; exp_addr = addr[31:2]; exp_wdata = wd;
            if (i == k) begin
                mem_bus.bus_ack = 1'b1;
                if (wr) begin
                    mem[addr[31:2]] = wd;
                end else begin
                    if (mem.exists(addr[31:2])) mem_bus.bus_rdata = mem[addr[31:2]];
                    pend_rd = mem_bus.bus_rdata;
                end
            end
        end
        if (k >= int'(TO)) begin
            pend_err = 1'b1;
            if (!wr) pend_rd = ERRV;
        end
        next_cycle();
        exp_req = 1'b0; exp_stall = 1'b0;
        bus_noise();
        next_cycle();
    endtask

    initial begin
        logic [31:0] a;
        int          sel, k;

        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ALUResult = '0; WriteData = '0;
        mem_bus.bus_ack = 1'b0; mem_bus.bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_rd = '0;
        exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
        chk_en = 1'b1;
        check("rst_bus_we",    32'(mem_bus.bus_we),   32'd0);
        check("rst_bus_addr",  32'(mem_bus.bus_addr), 32'd0);
        check("rst_bus_wdata", mem_bus.bus_wdata,     32'd0);
        check("rst_readdata",  ReadData,              32'd0);

        // Load, immediate ack.
        clear_counts();
        mem[30'h10] = 32'h1234_5678;
        run_instr(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0);
        run_instr(1'b0, 1'b0, 32'h0, 32'h0, 0);
        check("t1_readdata", ReadData,         32'h1234_5678);
        check("t1_addr",     32'(last_addr),   32'h10);
        check("t1_stall",    32'(stall_cnt),   32'd2);
        check("t1_err",      32'(err_cnt),     32'd0);

        // Store, three wait cycles.
        clear_counts();
        run_instr(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 3);
        run_instr(1'b0, 1'b0, 32'h0, 32'h0, 0);
        check("t2_stall",    32'(stall_cnt),   32'd5);
        check("t2_req",      32'(req_cnt),     32'd4);
        check("t2_readdata", ReadData,         32'h1234_5678);

        // Misaligned load.
        clear_counts();
        run_instr(1'b1, 1'b0, 32'h0000_0042, 32'h0, 0);
        run_instr(1'b0, 1'b0, 32'h0, 32'h0, 0);
        check("t3_req",      32'(req_cnt),     32'd0);
        check("t3_stall",    32'(stall_cnt),   32'd0);
        check("t3_err",      32'(err_cnt),     32'd1);
        check("t3_readdata", ReadData,         32'd0);

        // Load timeout.
        clear_counts();
        run_instr(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1000);
        run_instr(1'b0, 1'b0, 32'h0, 32'h0, 0);
        check("t4_req",      32'(req_cnt),     32'd16);
        check("t4_stall",    32'(stall_cnt),   32'd17);
        check("t4_err",      32'(err_cnt),     32'd1);
        check("t4_readdata", ReadData,         32'hDEAD_BEEF);

        // Reset in the second request cycle, then a late ack.
        clear_counts();
        MemRead = 1'b1; MemWrite = 1'b0; ALUResult = 32'h48; WriteData = 32'h0;
        exp_stall = 1'b1; exp_req = 1'b0;
        next_cycle();
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 30'h12; exp_wdata = 32'h0;
        next_cycle();
        reset = 1'b1;
        pend_rd = '0;
        next_cycle();
        reset = 1'b0; MemRead = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0;
        mem_bus.bus_ack = 1'b1; mem_bus.bus_rdata = 32'h55AA_55AA;
        next_cycle();
        run_instr(1'b0, 1'b0, 32'h0, 32'h0, 0);
        check("t5_req",      32'(req_cnt),     32'd2);
        check("t5_readdata", ReadData,         32'd0);

        // Store then load to the same word.
        clear_counts();
        run_instr(1'b0, 1'b1, 32'h0000_0100, 32'h0BAD_F00D, 1);
        run_instr(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2);
        run_instr(1'b0, 1'b0, 32'h0, 32'h0, 0);
        check("t6_readdata", ReadData,         32'h0BAD_F00D);
        check("t6_rises",    32'(req_rise),    32'd2);
        check("t6_req",      32'(req_cnt),     32'd5);

        // Randomized instruction stream.
        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 9);
            a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0:       k = 15;
                    1:       k = 16;
                    default: k = 40;
                endcase
            end else begin
                k = $urandom_range(0, 4);
            end
            case (sel)
                0, 1:       run_instr(1'b0, 1'b0, a, $urandom, k);
                2, 3, 4, 5: run_instr(1'b1, 1'b0, a, $urandom, k);
                6, 7, 8:    run_instr(1'b0, 1'b1, a, $urandom, k);
                default:    run_instr(1'b1, 1'b1, a, $urandom, k);
            endcase
        end
        run_instr(1'b0, 1'b0, 32'h0, 32'h0, 0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_access.md
Name: data_mem_access

Overview:
- Load/store stage sitting directly downstream of the single-cycle ARM datapath.
- Consumes the datapath's address output (ALUResult), WriteData and the control unit's decoded MemRead/MemWrite, and returns ReadData to the datapath.
- Converts single-cycle memory instructions into a req/ack bus transaction to a multi-cycle RAM/peripheral bus.
- Raises Stall so the top level can hold the PC (deassert the datapath PC enable) and gate RegWrite until the access completes.

Parameters:
- DATA_W, 32, data and address width.
- TIMEOUT, 16, maximum cycles in REQ waiting for bus_ack before aborting; must be >= 1.
- ERR_DATA, 32'hDEADBEEF, ReadData value returned on a timed-out load.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- MemRead  input  1  current instruction is a load (LDR).
- MemWrite  input  1  current instruction is a store (STR).
- ALUResult  input  DATA_W  byte address from the datapath.
- WriteData  input  DATA_W  store data from the datapath.
- ReadData  output  DATA_W  load data to the datapath result mux.
- Stall  output  1  high while the current memory instruction must not retire.
- MemErr  output  1  one-cycle pulse on a misaligned access or a timeout.
- bus_req  output  1  bus request, held until acknowledged.
- bus_we  output  1  1 = write, 0 = read.
- bus_addr  output  DATA_W-2  word address.
- bus_wdata  output  DATA_W  write data.
- bus_rdata  input  DATA_W  read data, valid when bus_ack = 1.
- bus_ack  input  1  single-cycle acknowledge.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state = IDLE, bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, ReadData = 0, MemErr = 0, timeout counter = 0, Stall = 0.

FSM (IDLE, REQ, DONE):
- IDLE:
  - acc = MemRead | MemWrite.
  - acc and ALUResult[1:0] == 0: Stall = 1 combinationally. Latch bus_we = MemWrite, bus_addr = ALUResult[DATA_W-1:2], bus_wdata = WriteData; go to REQ.
  - acc and ALUResult[1:0] != 0: no bus cycle, Stall = 0, ReadData = 0, MemErr pulses for the next cycle, stay in IDLE.
  - MemRead and MemWrite both high: treated as a store.
- REQ:
  - bus_req = 1, Stall = 1; counter increments each cycle.
  - bus_ack = 1: capture ReadData = bus_rdata (loads only; stores leave ReadData unchanged), go to DONE.
  - Counter reaches TIMEOUT-1 without an ack: ReadData = ERR_DATA for loads, MemErr pulses, go to DONE.
  - bus_addr, bus_we and bus_wdata stay stable throughout REQ.
- DONE:
  - Stall = 0 and bus_req = 0, so the instruction retires at this clock edge; always returns to IDLE.
  - A new request is never started in DONE, because the retiring instruction is still presented.
- bus_req is decoded from the registered state and never glitches.
- Latency: with bus_ack arriving k cycles after bus_req rises, Stall is high for k+2 cycles and the instruction occupies k+3 cycles. Minimum is 3 cycles (Stall high for 2).
- bus_ack outside REQ: ignored.
- Reset mid-access: at the reset edge the block returns to IDLE and bus_req drops; a late bus_ack is ignored.
- Non-memory instructions: Stall = 0, no bus activity, ReadData holds its last value.

Decomposition:
- Package mem_access_pkg holds:
  - the typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  - the ERR_DATA default constant;
  - the ALIGN_MASK = 2'b11 constant.
- One sub-module, timeout_counter (clear, enable, terminal-count flag, parameter TIMEOUT), used for the REQ watchdog.

Test Plan:
1. Load, ack immediate: MemRead = 1, ALUResult = 0x0000_0040, bus_ack in the first REQ cycle with bus_rdata = 0x1234_5678 -> bus_addr = 0x10, bus_we = 0, Stall high 2 cycles, ReadData = 0x1234_5678 in DONE, MemErr = 0.
2. Store with 3 wait cycles: MemWrite = 1, ALUResult = 0x80, WriteData = 0xCAFE_F00D, ack 3 cycles after bus_req rises -> bus_we = 1, bus_wdata stable across all REQ cycles, Stall high 5 cycles, ReadData unchanged.
3. Misaligned: MemRead = 1, ALUResult = 0x42 -> bus_req never asserts, Stall = 0, MemErr pulses once, ReadData = 0.
4. Timeout: load with bus_ack held low, TIMEOUT = 16 -> bus_req high exactly 16 cycles, then DONE with ReadData = 0xDEADBEEF and MemErr pulsed once.
5. Reset mid-REQ: assert reset in the second REQ cycle, then apply bus_ack one cycle later -> after the reset edge state = IDLE, bus_req = 0, Stall = 0, and the late ack does not change ReadData.
6. Back-to-back: store at 0x100 followed by load at 0x100 with an echoing memory model -> two separate REQ phases separated by DONE/IDLE, load returns the stored value, no double-issue of either access.
